scan_line_sequencer: RTL and testbench
======================================

SCAN_LINE_SEQUENCER -- requirements
Module: scan_line_sequencer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, active pixels per scan line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter SYNC_TIMEOUT, default 2000000, clk cycles without facet_sync before sync loss.
REQ-004 clk  in  1  system clock, rising edge; the only clock.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  run/stop; sampled each cycle.
REQ-007 facet_sync  in  1  one-cycle pulse per polygon facet, already synchronised to clk.
REQ-008 line_delay  in  16  clk cycles from facet_sync to first pixel.
REQ-009 pixel_div  in  8  clk cycles per pixel minus 1.
REQ-010 fetch_req  out  1  request that line buffer be loaded with line fetch_line.
REQ-011 fetch_line  out  10  line index to fetch; stable while fetch_req=1.
REQ-012 fetch_ack  in  1  line buffer loaded; one-cycle pulse.
REQ-013 pixel_valid  out  1  laser pixel strobe.
REQ-014 pixel_x, pixel_y  out  10 each  current pixel coordinates.
REQ-015 galvo_step  out  1  one-cycle pulse: advance vertical galvo one line.
REQ-016 frame_start  out  1  one-cycle pulse: vertical galvo home, new frame.
REQ-017 line_skipped  out  1  one-cycle pulse: facet arrived before line data ready.
REQ-018 sync_lost  out  1  sticky flag: facet_sync timeout.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ARMED, DELAY, SCAN.
REQ-020 IDLE: enable=1 -> FETCH with line counter y=0, frame_start pulsed same transition.
REQ-021 FETCH: fetch_req=1, fetch_line=y; fetch_ack -> ARMED next cycle; fetch_req drops the cycle after fetch_ack.
REQ-022 ARMED: facet_sync -> DELAY, delay counter loaded with line_delay; line_delay=0 -> SCAN directly.
REQ-023 FETCH receiving facet_sync SHALL pulse line_skipped, stay in FETCH, keep y unchanged.
REQ-024 DELAY: counts line_delay cycles, then SCAN; first pixel_valid exactly line_delay+1 cycles after facet_sync.
REQ-025 SCAN: pixel_valid high for one cycle every pixel_div+1 cycles (continuously when pixel_div=0), pixel_x 0..H_PIXELS-1, pixel_y=y.
REQ-026 After pixel H_PIXELS-1: galvo_step pulse, y increments, -> FETCH; when y was V_LINES-1, y wraps to 0 and frame_start pulses instead of galvo_step.
REQ-027 facet_sync during DELAY or SCAN SHALL be ignored (no restart).
REQ-028 line_delay and pixel_div SHALL be sampled at facet_sync and held for the line.
REQ-029 enable=0 in any state -> IDLE next cycle; outputs deasserted; fetch_req abandoned.
REQ-030 Timeout counter SHALL clear on each facet_sync, increment otherwise while enable=1; reaching SYNC_TIMEOUT sets sync_lost and forces IDLE; sync_lost clears only on reset or enable 1->0.
REQ-031 Counters SHALL be width-sized from parameters; no wrap beyond H_PIXELS-1/V_LINES-1.

Reset
REQ-032 On reset_n=0: state IDLE, y=0, all counters 0, all outputs 0, sync_lost=0, independent of clk.
REQ-033 Reset deassertion mid-frame SHALL restart at line 0 with frame_start on first enabled cycle.

Structure
REQ-034 State enumeration, default H_PIXELS/V_LINES and coordinate width constant SHALL live in shared package projector_pkg.
REQ-035 Pixel-rate divider/x counter SHALL be sub-module pixel_strobe_gen; rest is one module.

Verification
REQ-036 enable=1, fetch_ack 3 cycles after fetch_req, facet_sync, line_delay=10, pixel_div=1 -> first pixel_valid 11 cycles after facet, 640 strobes 2 cycles apart, then galvo_step, fetch_line=1.
REQ-037 V_LINES=4 run 4 lines -> galvo_step x3, frame_start after line 3, fetch_line returns 0.
REQ-038 facet_sync while fetch_ack withheld -> line_skipped pulse, y unchanged, next facet after ack scans that line.
REQ-039 No facet_sync with SYNC_TIMEOUT=100 -> sync_lost set at cycle 100, state IDLE, cleared by enable toggle.
REQ-040 reset_n asserted mid-SCAN -> all outputs 0 immediately; after release, frame_start and fetch_line=0.
REQ-041 line_delay=0, pixel_div=0 -> pixel_valid the cycle after facet_sync, high 640 consecutive cycles.

Source files
------------

// File: rtl/projector_pkg.sv
// -----------------------------------------------------------------------------
// projector_pkg
// Shared definitions for the laser-projector scan path: sequencer state
// encoding, default raster geometry, the coordinate port width, and a helper
// that sizes counters from a parameter value.
// -----------------------------------------------------------------------------
package projector_pkg;

    localparam int DEF_H_PIXELS = 640;   // active pixels per scan line
    localparam int DEF_V_LINES  = 480;   // lines per frame
    localparam int COORD_W      = 10;    // width of fetch_line / pixel_x / pixel_y

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ARMED,
        ST_DELAY,
        ST_SCAN
    } seq_state_t;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// -----------------------------------------------------------------------------
// pixel_strobe_gen
// Pixel-rate divider and horizontal pixel counter for one scan line.
// A start pulse emits pixel 0 on the following cycle, then one strobe every
// i_div+1 cycles until pixel H_PIXELS-1 has been emitted.
//
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   i_run        : low aborts the line (enable dropped / sync lost)
//   i_start      : begin a line; i_div is captured and held for the line
//   i_div        : clk cycles per pixel minus 1
//   o_valid      : registered pixel strobe
//   o_x          : registered pixel column
//   o_last       : high while the strobe for the final pixel is out
// -----------------------------------------------------------------------------
module pixel_strobe_gen
    import projector_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic               i_start,
    input  logic [7:0]         i_div,
    output logic               o_valid,
    output logic [COORD_W-1:0] o_x,
    output logic               o_last
);

    localparam int            XW     = cnt_width(H_PIXELS);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);

    logic          r_active;
    logic          r_valid;
    logic [XW-1:0] r_x;
    logic [7:0]    r_div;
    logic [7:0]    r_div_cnt;
    logic          w_last;

    assign w_last = r_valid && (r_x == X_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here updates from the values present before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_div     <= '0;
            r_div_cnt <= '0;
        end else if (!i_run) begin
            r_active  <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_div_cnt <= '0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_valid   <= 1'b1;
            r_x       <= '0;
            r_div     <= i_div;
            r_div_cnt <= i_div;
        end else if (r_active) begin
            if (w_last) begin
                r_active <= 1'b0;
                r_valid  <= 1'b0;
                r_x      <= '0;
            end else if (r_div_cnt == 8'd0) begin
                // Period elapsed: strobe the next column and reload the divider.
                r_valid   <= 1'b1;
                r_x       <= r_x + 1'b1;
                r_div_cnt <= r_div;
            end else begin
                r_valid   <= 1'b0;
                r_div_cnt <= r_div_cnt - 8'd1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_x     = COORD_W'(r_x);
    assign o_last  = w_last;

endmodule

// File: rtl/scan_line_sequencer.sv
// -----------------------------------------------------------------------------
// scan_line_sequencer
// Sequences a polygon-mirror laser scanner: requests each line from the line
// buffer, waits for the facet sync pulse, delays to the start of the active
// region, strobes H_PIXELS pixels, then steps the vertical galvo (or homes it
// at the end of a frame). A watchdog flags lost facet sync.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : run/stop, low returns to IDLE next cycle
//   facet_sync              : one pulse per mirror facet (already synchronised)
//   line_delay, pixel_div   : facet-to-first-pixel delay, cycles per pixel - 1
//   fetch_req, fetch_line   : line-buffer load request and line index
//   fetch_ack               : line-buffer loaded pulse
//   pixel_valid/x/y         : laser pixel strobe and coordinates
//   galvo_step, frame_start : vertical galvo advance / home pulses
//   line_skipped            : facet arrived before the line data was ready
//   sync_lost               : sticky facet-sync timeout flag
// -----------------------------------------------------------------------------
module scan_line_sequencer
    import projector_pkg::*;
#(
    parameter int H_PIXELS     = DEF_H_PIXELS,
    parameter int V_LINES      = DEF_V_LINES,
    parameter int SYNC_TIMEOUT = 2000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               facet_sync,
    input  logic [15:0]        line_delay,
    input  logic [7:0]         pixel_div,
    output logic               fetch_req,
    output logic [COORD_W-1:0] fetch_line,
    input  logic               fetch_ack,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               galvo_step,
    output logic               frame_start,
    output logic               line_skipped,
    output logic               sync_lost
);

    localparam int            YW      = cnt_width(V_LINES);
    localparam int            TW      = cnt_width(SYNC_TIMEOUT);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_LINES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(SYNC_TIMEOUT - 1);

    seq_state_t    r_state;
    logic [YW-1:0] r_y;
    logic [15:0]   r_dly;
    logic [7:0]    r_pix_div;
    logic [TW-1:0] r_to_cnt;
    logic          r_fetch_req;
    logic          r_galvo_step;
    logic          r_frame_start;
    logic          r_line_skipped;
    logic          r_sync_lost;

    logic          w_to_hit;
    logic          w_run;
    logic          w_scan_start;
    logic [7:0]    w_start_div;
    logic          w_line_done;

    // The watchdog is parked while sync is already lost, so it fires once.
    assign w_to_hit = enable && !facet_sync && !r_sync_lost && (r_to_cnt == TO_LAST);
    assign w_run    = enable && !w_to_hit;

    // The strobe generator must be told on the same edge the FSM enters SCAN
    // so the first pixel is registered together with the state change.
    assign w_scan_start = w_run &&
                          (((r_state == ST_ARMED) && facet_sync && (line_delay == 16'd0)) ||
                           ((r_state == ST_DELAY) && (r_dly == 16'd1)));

    // A zero-delay line starts on the facet edge itself, before r_pix_div has
    // captured the divider, so take it straight from the input in that case.
    assign w_start_div = (r_state == ST_ARMED) ? pixel_div : r_pix_div;

    pixel_strobe_gen #(
        .H_PIXELS (H_PIXELS)
    ) u_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_run   (w_run),
        .i_start (w_scan_start),
        .i_div   (w_start_div),
        .o_valid (pixel_valid),
        .o_x     (pixel_x),
        .o_last  (w_line_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_y            <= '0;
            r_dly          <= '0;
            r_pix_div      <= '0;
            r_to_cnt       <= '0;
            r_fetch_req    <= 1'b0;
            r_galvo_step   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_line_skipped <= 1'b0;
            r_sync_lost    <= 1'b0;
        end else begin
            // NOTE: the one-cycle pulses default low here and are only raised
            // by the branch that owns them, which keeps every branch short.
            r_galvo_step   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_line_skipped <= 1'b0;

            if (facet_sync || !enable || r_sync_lost || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (!enable) begin
                r_state     <= ST_IDLE;
                r_fetch_req <= 1'b0;
                r_y         <= '0;
                r_sync_lost <= 1'b0;
            end else if (w_to_hit) begin
                r_state     <= ST_IDLE;
                r_fetch_req <= 1'b0;
                r_sync_lost <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Stay parked after a sync loss until enable is cycled.
                        if (!r_sync_lost) begin
                            r_state       <= ST_FETCH;
                            r_y           <= '0;
                            r_fetch_req   <= 1'b1;
                            r_frame_start <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (facet_sync) begin
                            r_line_skipped <= 1'b1;
                        end
                        if (fetch_ack) begin
                            r_fetch_req <= 1'b0;
                            r_state     <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (facet_sync) begin
                            r_pix_div <= pixel_div;
                            r_dly     <= line_delay;
                            r_state   <= (line_delay == 16'd0) ? ST_SCAN : ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (r_dly == 16'd1) begin
                            r_state <= ST_SCAN;
                        end else begin
                            r_dly <= r_dly - 16'd1;
                        end
                    end
                    ST_SCAN: begin
                        if (w_line_done) begin
                            r_state     <= ST_FETCH;
                            r_fetch_req <= 1'b1;
                            if (r_y == Y_LAST) begin
                                r_y           <= '0;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_y          <= r_y + 1'b1;
                                r_galvo_step <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign fetch_req    = r_fetch_req;
    assign fetch_line   = COORD_W'(r_y);
    assign pixel_y      = COORD_W'(r_y);
    assign galvo_step   = r_galvo_step;
    assign frame_start  = r_frame_start;
    assign line_skipped = r_line_skipped;
    assign sync_lost    = r_sync_lost;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_line_sequencer
// Directed bench. Instance u_dut runs a 640 x 4 raster with a long watchdog;
// instance u_dut_to (8 x 4, watchdog 100) is used only for the sync-loss case.
// Expected pixels are queued when a facet is driven and popped by a monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_line_sequencer;

    localparam int H  = 640;
    localparam int V  = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        facet_sync;
    logic [15:0] line_delay;
    logic [7:0]  pixel_div;
    logic        fetch_ack;

    logic        fetch_req;
    logic [9:0]  fetch_line;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        galvo_step;
    logic        frame_start;
    logic        line_skipped;
    logic        sync_lost;

    logic        en_b;
    logic        facet_b = 1'b0;
    logic        ack_b   = 1'b0;
    logic        fetch_req_b;
    logic [9:0]  fetch_line_b;
    logic        pixel_valid_b;
    logic [9:0]  pixel_x_b;
    logic [9:0]  pixel_y_b;
    logic        galvo_step_b;
    logic        frame_start_b;
    logic        line_skipped_b;
    logic        sync_lost_b;

    typedef struct {
        int x;
        int y;
        int t;
    } pix_t;

    pix_t sb[$];
    pix_t mon_e;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_mis   = 0;
    int   n_galvo = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_line_sequencer #(
        .H_PIXELS     (H),
        .V_LINES      (V),
        .SYNC_TIMEOUT (5000)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .facet_sync   (facet_sync),
        .line_delay   (line_delay),
        .pixel_div    (pixel_div),
        .fetch_req    (fetch_req),
        .fetch_line   (fetch_line),
        .fetch_ack    (fetch_ack),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .galvo_step   (galvo_step),
        .frame_start  (frame_start),
        .line_skipped (line_skipped),
        .sync_lost    (sync_lost)
    );

    scan_line_sequencer #(
        .H_PIXELS     (8),
        .V_LINES      (V),
        .SYNC_TIMEOUT (TO)
    ) u_dut_to (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (en_b),
        .facet_sync   (facet_b),
        .line_delay   (line_delay),
        .pixel_div    (pixel_div),
        .fetch_req    (fetch_req_b),
        .fetch_line   (fetch_line_b),
        .fetch_ack    (ack_b),
        .pixel_valid  (pixel_valid_b),
        .pixel_x      (pixel_x_b),
        .pixel_y      (pixel_y_b),
        .galvo_step   (galvo_step_b),
        .frame_start  (frame_start_b),
        .line_skipped (line_skipped_b),
        .sync_lost    (sync_lost_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({fetch_req, fetch_line, pixel_valid, pixel_x, pixel_y,
                    galvo_step, frame_start, line_skipped, sync_lost});
    endfunction

    function automatic logic [63:0] outs_b();
        return 64'({fetch_req_b, fetch_line_b, pixel_valid_b, pixel_x_b, pixel_y_b,
                    galvo_step_b, frame_start_b, line_skipped_b, sync_lost_b});
    endfunction

    // Scoreboard consumer: every strobe must match the next queued pixel.
    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_pixel", 64'(pixel_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pixel_x", 64'(pixel_x), 64'(mon_e.x));
                check("pixel_y", 64'(pixel_y), 64'(mon_e.y));
                check("pixel_time", 64'(cyc), 64'(mon_e.t));
            end
        end
        if (galvo_step === 1'b1) n_galvo++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Entered in a FETCH cycle; acks three cycles after the request rose.
    task automatic do_fetch(input int line);
        check("fetch_req_hold", 64'(fetch_req), 64'd1);
        check("fetch_line", 64'(fetch_line), 64'(line));
        step();
        step();
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        check("fetch_req_drop", 64'(fetch_req), 64'd0);
    endtask

    // Entered in ARMED. Drives one facet, queues the expected line and runs
    // until the cycle after the last pixel, then checks the line-end pulses.
    task automatic scan_line(input int ld, input int div, input int line_y,
                             input bit stray, input bit wraps);
        int fc;
        int t_last;
        line_delay = 16'(ld);
        pixel_div  = 8'(div);
        facet_sync = 1'b1;
        fc = cyc + 1;
        for (int n = 0; n < H; n++) begin
            sb.push_back('{x: n, y: line_y, t: fc + ld + n * (div + 1)});
        end
        step();
        facet_sync = 1'b0;
        // Changing these mid-line must not disturb the line in progress.
        line_delay = 16'hffff;
        pixel_div  = 8'h07;
        t_last = fc + ld + (H - 1) * (div + 1);
        while (cyc < t_last + 1) begin
            if (stray && (cyc == fc + 1 || cyc == fc + ld + 50)) facet_sync = 1'b1;
            step();
            facet_sync = 1'b0;
        end
        check("line_pixels_left", 64'(sb.size()), 64'd0);
        check("galvo_step", 64'(galvo_step), 64'(!wraps));
        check("frame_start_eol", 64'(frame_start), 64'(wraps));
        check("fetch_req_next", 64'(fetch_req), 64'd1);
        check("fetch_line_next", 64'(fetch_line), wraps ? 64'd0 : 64'(line_y + 1));
    endtask

    initial begin
        int c;
        reset_n    = 1'b1;
        enable     = 1'b0;
        en_b       = 1'b0;
        facet_sync = 1'b0;
        line_delay = '0;
        pixel_div  = '0;
        fetch_ack  = 1'b0;

        // Reset takes effect without a clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("reset_outs_a", outs_a(), 64'd0);
        check("reset_outs_b", outs_b(), 64'd0);
        step();
        step();
        check("reset_hold_a", outs_a(), 64'd0);

        // Enable: frame_start with the IDLE->FETCH transition, line 0 requested.
        reset_n = 1'b1;
        enable  = 1'b1;
        step();
        check("frame_start_first", 64'(frame_start), 64'd1);
        check("fetch_req_first", 64'(fetch_req), 64'd1);
        check("fetch_line_first", 64'(fetch_line), 64'd0);
        step();
        check("frame_start_pulse", 64'(frame_start), 64'd0);

        // Line 0: delay 10, two cycles per pixel.
        do_fetch(0);
        scan_line(10, 1, 0, 1'b0, 1'b0);

        // Line 1: facet while the ack is withheld is skipped, y stays put.
        facet_sync = 1'b1;
        step();
        facet_sync = 1'b0;
        check("line_skipped", 64'(line_skipped), 64'd1);
        check("skip_fetch_line", 64'(fetch_line), 64'd1);
        check("skip_fetch_req", 64'(fetch_req), 64'd1);
        step();
        check("line_skipped_pulse", 64'(line_skipped), 64'd0);
        do_fetch(1);
        scan_line(0, 0, 1, 1'b0, 1'b0);

        // Line 2: stray facets during DELAY and SCAN are ignored.
        do_fetch(2);
        scan_line(3, 2, 2, 1'b1, 1'b0);

        // Line 3: last line of the frame wraps to 0 with frame_start.
        do_fetch(3);
        scan_line(1, 0, 3, 1'b0, 1'b1);
        check("galvo_count", 64'(n_galvo), 64'd3);

        // Dropping enable abandons the pending fetch.
        enable = 1'b0;
        step();
        check("disable_outs", outs_a(), 64'd0);
        step();
        check("disable_idle", outs_a(), 64'd0);
        enable = 1'b1;
        step();
        check("reenable_frame_start", 64'(frame_start), 64'd1);
        check("reenable_fetch_line", 64'(fetch_line), 64'd0);

        // Reset in the middle of a scan.
        do_fetch(0);
        line_delay = 16'd0;
        pixel_div  = 8'd0;
        facet_sync = 1'b1;
        fc_push(cyc + 1);
        step();
        facet_sync = 1'b0;
        repeat (20) step();
        #1 reset_n = 1'b0;
        #1;
        check("reset_mid_scan", outs_a(), 64'd0);
        sb.delete();
        step();
        check("reset_mid_scan_hold", outs_a(), 64'd0);
        reset_n = 1'b1;
        step();
        check("post_reset_frame_start", 64'(frame_start), 64'd1);
        check("post_reset_fetch_line", 64'(fetch_line), 64'd0);
        check("post_reset_fetch_req", 64'(fetch_req), 64'd1);

        // Sync loss on the short-watchdog instance.
        en_b = 1'b1;
        c = cyc;
        while (cyc < c + TO - 1) step();
        check("sync_lost_early", 64'(sync_lost_b), 64'd0);
        check("sync_fetch_req_early", 64'(fetch_req_b), 64'd1);
        step();
        check("sync_lost_set", 64'(sync_lost_b), 64'd1);
        check("sync_lost_idle", 64'(fetch_req_b), 64'd0);
        repeat (5) step();
        check("sync_lost_sticky", 64'(sync_lost_b), 64'd1);
        check("sync_lost_stay_idle", 64'(fetch_req_b), 64'd0);
        en_b = 1'b0;
        step();
        check("sync_lost_clear", 64'(sync_lost_b), 64'd0);
        en_b = 1'b1;
        step();
        check("sync_restart_frame", 64'(frame_start_b), 64'd1);
        check("sync_restart_fetch", 64'(fetch_req_b), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // Queue a zero-delay, one-cycle-per-pixel line starting at cycle fc.
    task automatic fc_push(input int fc);
        for (int n = 0; n < H; n++) begin
            sb.push_back('{x: n, y: 0, t: fc + n});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
